// File: rtl/pll_supervisor_pkg.sv
// Shared types and sizing helpers for the PLL supervisor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        RST_PLL,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAIL
    } sup_state_t;

    localparam int RETRY_W = 4;
    localparam int LOSS_W  = 8;

    // Width of the shared state counter: must hold the largest of the three limits.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/pll_supervisor_sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into the refclk domain.
// Latency: 2 refclk cycles.
// Backpressure: none.
module sync_2ff (
    input  logic refclk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_supervisor.sv
// PLL reset/lock supervisor with retry and FAIL handling; PLL_SUP_LOSS_CNT_EN adds a lock-loss counter.
// Latency: all outputs registered, one cycle after the deciding state/lock_s value.
// Backpressure: none; restart_i is a one-cycle request that always wins.
module pll_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRY     = 3
) (
    input  logic               refclk,
    input  logic               rst_n,
    input  logic               pll_locked_i,
    input  logic               restart_i,
    output logic               pll_rst_o,
    output logic               ready_o,
    output logic               fail_o,
    output logic               lost_lock_o,
    output logic [RETRY_W-1:0] retry_cnt_o,
    output logic [LOSS_W-1:0]  loss_cnt_o
);

    localparam int CNT_W = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

    sup_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_d;
    logic               lock_s;
    logic               loss_evt;

    sync_2ff u_sync (
        .refclk (refclk),
        .rst_n  (rst_n),
        .d      (pll_locked_i),
        .q      (lock_s)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        retry_d  = retry_cnt_o;
        loss_evt = 1'b0;
        if (restart_i) begin
            state_d = RST_PLL;
            retry_d = '0;
        end else begin
            case (state_q)
                RST_PLL: begin
                    if (cnt_q == CNT_W'(RST_CYCLES - 1)) state_d = WAIT_LOCK;
                    else                                 cnt_d   = cnt_q + 1'b1;
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = STABLE;
                    end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                        retry_d = retry_cnt_o + 1'b1;
                        state_d = (retry_d == RETRY_W'(MAX_RETRY)) ? FAIL : RST_PLL;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        state_d = WAIT_LOCK;
                    end else if (cnt_q >= CNT_W'(STABLE_CYCLES - 1)) begin
                        state_d = RUN;
                        retry_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state_d  = RST_PLL;
                        loss_evt = 1'b1;
                    end
                end
                FAIL: begin
                    state_d = FAIL;
                end
                default: begin
                    state_d = RST_PLL;
                end
            endcase
        end
        // The WAIT_LOCK cycle that saw lock_s already counts as the first stable cycle.
        if (restart_i || (state_d != state_q))
            cnt_d = (state_d == STABLE) ? CNT_W'(1) : '0;
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RST_PLL;
            cnt_q       <= '0;
            pll_rst_o   <= 1'b1;
            ready_o     <= 1'b0;
            fail_o      <= 1'b0;
            lost_lock_o <= 1'b0;
            retry_cnt_o <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pll_rst_o   <= (state_d == RST_PLL) || (state_d == FAIL);
            ready_o     <= (state_d == RUN);
            fail_o      <= (state_d == FAIL);
            lost_lock_o <= loss_evt;
            retry_cnt_o <= retry_d;
        end
    end

`ifdef PLL_SUP_LOSS_CNT_EN
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n)
            loss_cnt_o <= '0;
        else if (loss_evt && (loss_cnt_o != '1))
            loss_cnt_o <= loss_cnt_o + 1'b1;
    end
`else
    assign loss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pll_supervisor.sv
// Directed bench for pll_supervisor with a simple PLL model whose lock is gated by its reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_pll_supervisor;

    localparam int W_PLL_RST = 0;
    localparam int W_READY   = 1;
    localparam int W_FAIL    = 2;
    localparam int W_LOST    = 3;
`ifdef PLL_SUP_LOSS_CNT_EN
    localparam int LOSS_ONE = 1;
`else
    localparam int LOSS_ONE = 0;
`endif

    logic       refclk;
    logic       rst_n;
    logic       pll_locked_i;
    logic       restart_i;
    logic       pll_rst_o;
    logic       ready_o;
    logic       fail_o;
    logic       lost_lock_o;
    logic [3:0] retry_cnt_o;
    logic [7:0] loss_cnt_o;
    logic       lock_en;

    int checks = 0;
    int errors = 0;
    int n;

    // PLL model: reports lock only while out of reset and enabled.
    assign pll_locked_i = lock_en & ~pll_rst_o;

    pll_supervisor #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (20),
        .STABLE_CYCLES (8),
        .MAX_RETRY     (2)
    ) dut (
        .refclk       (refclk),
        .rst_n        (rst_n),
        .pll_locked_i (pll_locked_i),
        .restart_i    (restart_i),
        .pll_rst_o    (pll_rst_o),
        .ready_o      (ready_o),
        .fail_o       (fail_o),
        .lost_lock_o  (lost_lock_o),
        .retry_cnt_o  (retry_cnt_o),
        .loss_cnt_o   (loss_cnt_o)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge refclk);
        #1;
    endtask

    // Steps until the selected output equals val; n = steps taken, -1 if the bound expires.
    task automatic wait_sig(input int which, input logic val, output int cnt);
        logic s;
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            cnt++;
            case (which)
                W_PLL_RST: s = pll_rst_o;
                W_READY:   s = ready_o;
                W_FAIL:    s = fail_o;
                default:   s = lost_lock_o;
            endcase
            if (s == val) return;
        end
        cnt = -1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pll_rst"}, int'(pll_rst_o), 1);
        chk({tag, "_ready"},   int'(ready_o), 0);
        chk({tag, "_fail"},    int'(fail_o), 0);
        chk({tag, "_lost"},    int'(lost_lock_o), 0);
        chk({tag, "_retry"},   int'(retry_cnt_o), 0);
        chk({tag, "_loss"},    int'(loss_cnt_o), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        restart_i = 1'b0;
        lock_en   = 1'b1;
        repeat (3) step();
        chk_reset_vals("reset");

        // Power-up with the PLL willing to lock.
        rst_n = 1'b1;
        wait_sig(W_PLL_RST, 1'b0, n);
        chk("pwr_rst_width", n, 4);
        wait_sig(W_READY, 1'b1, n);
        chk("pwr_ready_delay", n, 10);
        chk("pwr_retry", int'(retry_cnt_o), 0);
        chk("pwr_pll_rst", int'(pll_rst_o), 0);
        repeat (3) step();
        chk("run_ready_hold", int'(ready_o), 1);

        // One-cycle lock drop in RUN.
        lock_en = 1'b0;
        step();
        lock_en = 1'b1;
        wait_sig(W_LOST, 1'b1, n);
        chk("loss_pulse_delay", n, 2);
        chk("loss_ready", int'(ready_o), 0);
        chk("loss_pll_rst", int'(pll_rst_o), 1);
        chk("loss_cnt", int'(loss_cnt_o), LOSS_ONE);
        step();
        chk("loss_pulse_width", int'(lost_lock_o), 0);
        wait_sig(W_PLL_RST, 1'b0, n);
        chk("loss_rst_rest", n, 3);
        wait_sig(W_READY, 1'b1, n);
        chk("loss_relock", n, 10);

        // Restart from RUN, then a lock glitch in the fifth STABLE cycle.
        restart_i = 1'b1;
        step();
        restart_i = 1'b0;
        chk("rs1_pll_rst", int'(pll_rst_o), 1);
        chk("rs1_ready", int'(ready_o), 0);
        wait_sig(W_PLL_RST, 1'b0, n);
        chk("rs1_rst_width", n, 4);
        repeat (5) step();
        lock_en = 1'b0;
        step();
        lock_en = 1'b1;
        wait_sig(W_READY, 1'b1, n);
        chk("glitch_ready_delay", n, 10);
        chk("glitch_retry", int'(retry_cnt_o), 0);

        // No lock: restart lands on the exact timeout cycle.
        restart_i = 1'b1;
        lock_en   = 1'b0;
        step();
        restart_i = 1'b0;
        wait_sig(W_PLL_RST, 1'b0, n);
        chk("rs2_rst_width", n, 4);
        repeat (19) step();
        restart_i = 1'b1;
        step();
        restart_i = 1'b0;
        chk("tmo_rs_pll_rst", int'(pll_rst_o), 1);
        chk("tmo_rs_retry", int'(retry_cnt_o), 0);
        chk("tmo_rs_fail", int'(fail_o), 0);
        wait_sig(W_PLL_RST, 1'b0, n);
        chk("tmo_rs_rst_width", n, 4);

        // Lock never arrives: two timeouts then FAIL.
        wait_sig(W_PLL_RST, 1'b1, n);
        chk("tmo1_delay", n, 20);
        chk("tmo1_retry", int'(retry_cnt_o), 1);
        chk("tmo1_fail", int'(fail_o), 0);
        wait_sig(W_PLL_RST, 1'b0, n);
        chk("tmo1_rst_width", n, 4);
        wait_sig(W_FAIL, 1'b1, n);
        chk("tmo2_delay", n, 20);
        chk("tmo2_retry", int'(retry_cnt_o), 2);
        chk("fail_pll_rst", int'(pll_rst_o), 1);
        chk("fail_ready", int'(ready_o), 0);
        repeat (30) step();
        chk("fail_stuck", int'(fail_o), 1);
        chk("fail_rst_stuck", int'(pll_rst_o), 1);

        // Restart out of FAIL, then async reset in the middle of STABLE.
        lock_en   = 1'b1;
        restart_i = 1'b1;
        step();
        restart_i = 1'b0;
        chk("rs3_fail", int'(fail_o), 0);
        chk("rs3_retry", int'(retry_cnt_o), 0);
        chk("rs3_pll_rst", int'(pll_rst_o), 1);
        wait_sig(W_PLL_RST, 1'b0, n);
        chk("rs3_rst_width", n, 4);
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        chk_reset_vals("arst");
        step();
        rst_n = 1'b1;
        wait_sig(W_PLL_RST, 1'b0, n);
        chk("arst_rst_width", n, 4);
        wait_sig(W_READY, 1'b1, n);
        chk("arst_ready_delay", n, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
